// File: rtl/dmem_responder_pkg.sv
// Shared load/store width codes and responder FSM encoding.
// The funct3 values mirror the core decoder's RV32I load/store definitions.
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    if (we) return !(funct3 inside {F3_SB, F3_SH, F3_SW});
    return !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, replicated write
// data, sign/zero-extended load data and the natural-alignment check.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  assign byte_shift = rword_i >> {addr_lo_i, 3'b000};
  assign half_shift = rword_i >> {addr_lo_i[1], 4'b0000};

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    // funct3[1:0] is the access width, funct3[2] selects zero-extension.
    unique case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'h0, byte_shift[7:0]}
                              : {{24{byte_shift[7]}}, byte_shift[7:0]};
      end
      2'b01: begin
        misalign_o = addr_lo_i[0];
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = funct3_i[2] ? {16'h0, half_shift[15:0]}
                                 : {{16{half_shift[15]}}, half_shift[15:0]};
      end
      2'b10: begin
        misalign_o = (addr_lo_i != 2'b00);
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency,
// byte-enable word storage and error reporting for bad requests.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] load_data;
  logic        misalign;
  logic        out_of_range;
  logic        access_err;
  logic        mem_we;

  assign word_idx     = addr_q[AW+1:2];
  assign rword        = mem[word_idx];
  assign out_of_range = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
  assign access_err   = misalign || out_of_range || funct3_illegal(we_q, f3_q);

  dmem_lane_align u_lane_align (
    .funct3_i   (f3_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_sh),
    .rdata_o    (load_data),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = access_err;
          rdata_d = (access_err || we_q) ? 32'h0 : load_data;
          mem_we  = we_q && !access_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto RAM; reset only
  // blocks a pending commit, it never clears contents.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder: latency, lane steering, errors,
// response back-pressure and reset abort.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LAT     = 2;
  localparam logic [31:0] OOR     = 32'(4 * DEPTH);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at #1 after a posedge with the DUT idle; returns once rsp_valid is
  // seen (or the bound expires) and reports the measured latency.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input string name, output int lat);
    check({name, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check({name, "_lat"}, 32'(lat), 32'(LAT));
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_req(input vec_t v, input string name);
    int lat;
    issue(v.we, v.addr, v.wdata, v.f3, name, lat);
    check({name, "_rdata"}, rsp_rdata, v.exp_rdata);
    check({name, "_err"}, {31'h0, rsp_err}, {31'h0, v.exp_err});
    handshake();
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    bit saw_valid;

    vecs = '{
      '{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0},
      '{1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 1'b0},
      '{1'b0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 1'b0},
      '{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 1'b0},
      '{1'b1, 32'h11,  32'hAAAAAA55, 3'b000, 32'h0,        1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 1'b0},
      '{1'b1, 32'h12,  32'hFFFF1234, 3'b001, 32'h0,        1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b010, 32'h123455EF, 1'b0},
      '{1'b0, 32'h11,  32'h0,        3'b010, 32'h0,        1'b1},
      '{1'b1, 32'h13,  32'h0000FFFF, 3'b001, 32'h0,        1'b1},
      '{1'b0, OOR,     32'h0,        3'b010, 32'h0,        1'b1},
      '{1'b0, 32'h10,  32'h0,        3'b010, 32'h123455EF, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1},
      '{1'b1, 32'h10,  32'h0,        3'b100, 32'h0,        1'b1},
      '{1'b1, OOR,     32'h0,        3'b010, 32'h0,        1'b1},
      '{1'b0, 32'h10,  32'h0,        3'b010, 32'h123455EF, 1'b0},
      '{1'b0, 32'h11,  32'h0,        3'b000, 32'h00000055, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b001, 32'h000055EF, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b110, 32'h0,        1'b1},
      '{1'b1, 32'h20,  32'hCAFEF00D, 3'b010, 32'h0,        1'b0},
      '{1'b0, 32'h20,  32'h0,        3'b010, 32'hCAFEF00D, 1'b0}
    };

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'h0, rsp_err},   32'h0);

    foreach (vecs[i]) do_req(vecs[i], $sformatf("v%0d", i));

    // Back-pressure: hold the response while the request bus churns.
    issue(1'b0, 32'h10, 32'h0, 3'b010, "bp", lat);
    for (int c = 0; c < 5; c++) begin
      req_valid  = 1'b1;
      req_we     = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_valid", c), {31'h0, rsp_valid}, 32'h1);
      check($sformatf("bp%0d_rdata", c), rsp_rdata, 32'h123455EF);
      check($sformatf("bp%0d_err", c),   {31'h0, rsp_err},   32'h0);
      check($sformatf("bp%0d_ready", c), {31'h0, req_ready}, 32'h0);
    end
    // Store pending on the bus during the handshake edge must not be taken.
    req_we     = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    req_funct3 = 3'b010;
    handshake();
    req_valid = 1'b0;
    check("bp_done_valid", {31'h0, rsp_valid}, 32'h0);
    check("bp_done_ready", {31'h0, req_ready}, 32'h1);
    do_req('{1'b0, 32'h10, 32'h0, 3'b010, 32'h123455EF, 1'b0}, "bp_after");

    // Reset during WAIT discards the store and produces no response.
    check("ab_ready", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h1;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("ab_in_wait", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("ab_rst_rdata", rsp_rdata, 32'h0);
    check("ab_rst_err",   {31'h0, rsp_err}, 32'h0);
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) saw_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    check("ab_no_rsp", {31'h0, saw_valid}, 32'h0);
    do_req('{1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0}, "ab_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words of storage; legal range 2..65536, power of two.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response valid; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port req_valid  input  1  initiator presents a request.
REQ-006 Port req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
REQ-010 Port req_funct3  input  3  RV32I load/store funct3 width code.
REQ-011 Port rsp_valid  output  1  response available.
REQ-012 Port rsp_ready  input  1  initiator accepts the response.
REQ-013 Port rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-014 Port rsp_err  output  1  request was misaligned, out of range or had an illegal funct3.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; req_ready = 1 only in IDLE; one request outstanding at most.
REQ-016 IDLE: req_valid=1 -> latch we/addr/wdata/funct3, load counter with LATENCY-1, go to WAIT at that edge (acceptance edge).
REQ-017 WAIT: counter != 0 -> decrement; counter == 0 -> perform access, register rsp_rdata/rsp_err, go to RESP; rsp_valid therefore rises exactly LATENCY cycles after the acceptance edge.
REQ-018 RESP: rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_ready=1, then go to IDLE at that edge; no new request is accepted in the same cycle.
REQ-019 Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW returns the full word; the byte/halfword lane is selected by addr[1:0]/addr[1] (little-endian).
REQ-020 Stores: SB writes only byte lane addr[1:0]; SH writes only halfword lane addr[1]; SW writes all 4 lanes; unselected bytes are left unchanged.
REQ-021 Error conditions: halfword access with addr[0]=1; word access with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-022 On error: rsp_err=1, rsp_rdata=0, memory unmodified; latency and handshake are identical to a successful access.
REQ-023 Input changes while in WAIT or RESP are ignored; only the values latched at the acceptance edge are used.
REQ-024 A store followed by a load to the same address returns the newly stored data (no stale read).

Reset
REQ-025 While rst_n=0 at a rising edge: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request fields cleared.
REQ-026 Reset in WAIT or RESP aborts the transaction; a store not yet committed is discarded; no response is produced.
REQ-027 Memory contents are not cleared by reset.

Structure
REQ-028 Shared package holds the funct3 width codes (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state encoding; the codes are shared with the core's decoder definitions.
REQ-029 One combinational sub-module dmem_lane_align: from funct3, addr[1:0], wdata and the read word, it produces the byte enables, the shifted write data, the extended load data and the misalign flag.
REQ-030 Storage is a word array with per-byte write enables, synthesizable as inferred RAM.

Verification
REQ-031 LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid rises 2 cycles after each acceptance; rdata=0xDEADBEEF, err=0.
REQ-032 After REQ-031: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-033 SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF; SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
REQ-034 LW 0x11, SH 0x13, and LW at address 4*DEPTH_WORDS -> err=1, rdata=0; a following LW 0x10 still returns 0x123455EF.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP while toggling req_* -> rsp_valid/rdata/err are stable and req_ready=0; handshake then returns to IDLE.
REQ-036 Accept SW 0x20 data 0x1, assert rst_n=0 during WAIT -> no response; after reset, LW 0x20 returns the prior contents (store discarded).
